// File: rtl/diff_frame_rx.sv
// diff_frame_rx: serial frame receiver (start, MSB-first data, even parity, stop) with code/error strobes
module diff_frame_rx #(
    parameter int BIT_CYCLES = 16,
    parameter int DATA_WIDTH = 26
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  data_in,
    output logic [DATA_WIDTH-1:0] code_out,
    output logic                  new_code_out,
    output logic                  error_out,
    output logic [2:0]            state_out
);
    localparam int CW = $clog2(BIT_CYCLES);
    localparam int IW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    logic [1:0]            r_sync;
    state_t                r_state, w_state_nx;
    logic [CW-1:0]         r_cnt, w_cnt_nx;
    logic [IW-1:0]         r_idx, w_idx_nx;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_nx;
    logic                  r_par, w_par_nx;
    logic [DATA_WIDTH-1:0] r_code, w_code_nx;
    logic                  r_new, w_new_nx;
    logic                  r_err, w_err_nx;
    logic                  w_s, w_half, w_tick;

    assign w_s    = r_sync[1];
    assign w_half = (r_cnt == CW'(BIT_CYCLES / 2 - 1));
    assign w_tick = (r_cnt == CW'(BIT_CYCLES - 1));

    assign code_out     = r_code;
    assign new_code_out = r_new;
    assign error_out    = r_err;
    assign state_out    = r_state;

    // two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_sync <= 2'b11;
        else        r_sync <= {r_sync[0], data_in};
    end

    // state and datapath registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_code  <= '0;
            r_new   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_shift <= w_shift_nx;
            r_par   <= w_par_nx;
            r_code  <= w_code_nx;
            r_new   <= w_new_nx;
            r_err   <= w_err_nx;
        end
    end

    // next-state, bit sampling, parity accumulation and strobe generation
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 1'b1;
        w_idx_nx   = r_idx;
        w_shift_nx = r_shift;
        w_par_nx   = r_par;
        w_code_nx  = r_code;
        w_new_nx   = 1'b0;
        w_err_nx   = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nx = '0;
                if (!w_s) w_state_nx = START;
            end
            START: if (w_half) begin
                w_cnt_nx   = '0;
                w_idx_nx   = '0;
                w_par_nx   = 1'b0;
                w_state_nx = w_s ? IDLE : DATA;
            end
            DATA: if (w_tick) begin
                w_cnt_nx   = '0;
                w_shift_nx = {r_shift[DATA_WIDTH-2:0], w_s};
                w_par_nx   = r_par ^ w_s;
                w_idx_nx   = r_idx + 1'b1;
                if (r_idx == IW'(DATA_WIDTH - 1)) w_state_nx = PARITY;
            end
            PARITY: if (w_tick) begin
                w_cnt_nx   = '0;
                w_par_nx   = r_par ^ w_s;
                w_state_nx = STOP;
            end
            STOP: if (w_tick) begin
                w_cnt_nx   = '0;
                w_new_nx   = w_s && !r_par;
                w_err_nx   = !(w_s && !r_par);
                w_code_nx  = (w_s && !r_par) ? r_shift : r_code;
                w_state_nx = w_s ? IDLE : BREAK;
            end
            BREAK: begin
                w_cnt_nx = '0;
                if (w_s) w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_diff_frame_rx.sv
// tb_diff_frame_rx: directed plus randomized frames checked against a frame-level model
module tb_diff_frame_rx;
    localparam int BC = 8;
    localparam int DW = 26;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          data_in = 1'b1;
    logic [DW-1:0] code_out;
    logic          new_code_out, error_out;
    logic [2:0]    state_out;

    int checks = 0, failures = 0;
    int cyc = 0, n_new = 0, n_err = 0;
    bit both_high = 1'b0;
    logic [DW-1:0] exp_code = '0;
    logic [DW-1:0] q_code[$];
    int            q_time[$];

    diff_frame_rx #(.BIT_CYCLES(BC), .DATA_WIDTH(DW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in),
        .code_out(code_out), .new_code_out(new_code_out),
        .error_out(error_out), .state_out(state_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc++;

    // observe strobes away from the active edge
    always @(negedge clk_in) begin
        if (new_code_out) begin
            n_new++;
            q_code.push_back(code_out);
            q_time.push_back(cyc);
        end
        if (error_out) n_err++;
        if (new_code_out && error_out) both_high = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        repeat (BC) @(posedge clk_in);
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] c, input logic p, input logic st);
        send_bit(1'b0);
        for (int i = DW - 1; i >= 0; i--) send_bit(c[i]);
        send_bit(p);
        send_bit(st);
    endtask

    // frame-level model: accepted iff stop is high and data plus parity has even weight
    task automatic run_frame(input string tag, input logic [DW-1:0] c, input logic p, input logic st);
        int  n0 = n_new, e0 = n_err;
        bit  good = st && ((^c ^ p) == 1'b0);
        send_frame(c, p, st);
        repeat (4) @(posedge clk_in);
        @(negedge clk_in);
        if (good) exp_code = c;
        chk({tag, "_new"}, n_new - n0, good ? 1 : 0);
        chk({tag, "_err"}, n_err - e0, good ? 0 : 1);
        chk({tag, "_code"}, code_out, exp_code);
        chk({tag, "_state"}, state_out, st ? 0 : 5);
    endtask

    initial begin
        int n0, e0;
        bit all5;
        logic [DW-1:0] c;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_code", code_out, 0);
        chk("rst_new", new_code_out, 0);
        chk("rst_err", error_out, 0);
        chk("rst_state", state_out, 0);
        rst_in = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;

        run_frame("ones", 26'h3FFFFFF, 1'b0, 1'b1);
        run_frame("odd_ok", 26'h0000001, 1'b1, 1'b1);
        run_frame("odd_badpar", 26'h0000001, 1'b0, 1'b1);

        n0 = n_new; e0 = n_err;
        data_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1 data_in = 1'b1;
        repeat (20) @(posedge clk_in);
        @(negedge clk_in);
        chk("glitch_new", n_new - n0, 0);
        chk("glitch_err", n_err - e0, 0);
        chk("glitch_state", state_out, 0);
        chk("glitch_code", code_out, exp_code);

        run_frame("brk_frame", 26'h0000123, ^26'h0000123, 1'b0);
        all5 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_in);
            if (state_out !== 3'd5) all5 = 1'b0;
        end
        chk("brk_hold", all5, 1);
        data_in = 1'b1;
        repeat (4) @(posedge clk_in);
        @(negedge clk_in);
        chk("brk_release", state_out, 0);
        run_frame("after_brk", 26'h2AAAAAA, ^26'h2AAAAAA, 1'b1);

        q_code.delete();
        q_time.delete();
        send_frame(26'h1234567, ^26'h1234567, 1'b1);
        send_frame(26'h0ABCDEF, ^26'h0ABCDEF, 1'b1);
        repeat (4) @(posedge clk_in);
        @(negedge clk_in);
        chk("b2b_count", q_code.size(), 2);
        if (q_code.size() == 2) begin
            chk("b2b_first", q_code[0], 26'h1234567);
            chk("b2b_second", q_code[1], 26'h0ABCDEF);
            chk("b2b_gap", q_time[1] - q_time[0], 29 * BC);
        end
        exp_code = 26'h0ABCDEF;
        chk("b2b_code", code_out, exp_code);

        for (int k = 0; k < 12; k++) begin
            c = DW'($urandom);
            run_frame("rand", c, ^c ^ ($urandom_range(0, 3) == 0), 1'b1);
            repeat ($urandom_range(0, 20)) @(posedge clk_in);
            #1;
        end

        send_bit(1'b0);
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        data_in = 1'b0;
        repeat (BC / 2) @(posedge clk_in);
        @(negedge clk_in);
        chk("mid_state", state_out, 2);
        #2 rst_in = 1'b1;
        #1;
        chk("arst_code", code_out, 0);
        chk("arst_state", state_out, 0);
        chk("arst_strobes", {new_code_out, error_out}, 0);
        exp_code = '0;
        data_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;
        run_frame("after_rst", 26'h155AA55, ^26'h155AA55, 1'b1);

        chk("never_both", both_high, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
